// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-image loader: FSM state encoding, data
// width and the header-count format (8-bit count, value 0 stands for 256).
package prog_loader_pkg;

  localparam int DATA_W = 8;
  localparam int HDR_W  = 8;
  localparam int CNT_W  = HDR_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Header byte to payload length: 0 encodes a full 256-byte image.
  function automatic logic [CNT_W-1:0] hdr_count(input logic [HDR_W-1:0] hdr);
    if (hdr == '0) return {1'b1, {HDR_W{1'b0}}};
    return {1'b0, hdr};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and memory write bus of the boot-image loader.
// The slave modport is the loader; the master modport is the stream source
// plus the memory being written.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;

  modport master (
    output in_valid, in_data,
    input  in_ready, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/prog_loader.sv
// Boot-image loader: receives a header byte N, N payload bytes and, when
// PROG_LOADER_CKSUM_EN is defined, a trailing 8-bit sum checksum. Payload is
// written to memory from BASE_ADDR upward while the CPU is held; the CPU is
// released once the image is stored (and verified). Without
// PROG_LOADER_CKSUM_EN there is no CHECK/ERR path and error is tied low.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter logic [DATA_W-1:0] BASE_ADDR = 8'h00
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.slave  bus,
  input  logic          reload,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] sum;
  logic              ready;
  logic              accept;

  logic              vld_p1;
  logic [DATA_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  // Which states take a byte; reset blocks every transfer.
  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE:  ready = 1'b1;
      ST_LOAD:  ready = (remaining != '0);
`ifdef PROG_LOADER_CKSUM_EN
      ST_CHECK: ready = 1'b1;
`endif
      default:  ready = 1'b0;
    endcase
    if (reset) ready = 1'b0;
  end

  assign accept = ready & bus.in_valid;

  // Next-state logic. Without a checksum, LOAD lingers one cycle with
  // remaining == 0 so the last write drains before done rises.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_LOAD;
`ifdef PROG_LOADER_CKSUM_EN
      ST_LOAD:  if (accept && remaining == CNT_W'(1)) state_nxt = ST_CHECK;
      ST_CHECK: if (accept) state_nxt = (bus.in_data == sum) ? ST_RUN : ST_ERR;
      ST_ERR:   if (reload) state_nxt = ST_IDLE;
`else
      ST_LOAD:  if (remaining == '0) state_nxt = ST_RUN;
`endif
      ST_RUN:  if (reload) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Counters, running sum and the one-deep write pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      addr      <= '0;
      sum       <= '0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
    end else begin
      vld_p1 <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            remaining <= hdr_count(bus.in_data);
            addr      <= BASE_ADDR;
            sum       <= '0;
          end
          ST_LOAD: begin
            remaining <= remaining - CNT_W'(1);
            addr      <= addr + DATA_W'(1);
            sum       <= sum + bus.in_data;
            // ---- stage p1: write issued one cycle after acceptance ----
            vld_p1    <= 1'b1;
            addr_p1   <= addr;
            data_p1   <= bus.in_data;
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs are forced to their idle values while reset is high, which also
  // cancels a write that would otherwise appear in that cycle.
  assign bus.in_ready  = ready;
  assign bus.mem_we    = vld_p1 & ~reset;
  assign bus.mem_addr  = reset ? '0 : addr_p1;
  assign bus.mem_wdata = reset ? '0 : data_p1;
  assign cpu_hold      = reset | (state != ST_RUN);
  assign done          = ~reset & (state == ST_RUN);
`ifdef PROG_LOADER_CKSUM_EN
  assign error         = ~reset & (state == ST_ERR);
`else
  assign error         = 1'b0;
`endif

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: BASE_ADDR, default 8'h00, first memory address written by a load.
REQ-002 Port: clk  input  1  system clock; all state updates on posedge clk.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 Port: in_valid  input  1  serial byte-stream source has a byte.
REQ-005 Port: in_data  input  8  stream byte.
REQ-006 Port: in_ready  output  1  loader accepts a byte; transfer occurs on a posedge where in_valid && in_ready.
REQ-007 Port: reload  input  1  single-cycle request to return from RUN/ERR to IDLE.
REQ-008 Port: mem_addr  output  8  memory write address.
REQ-009 Port: mem_wdata  output  8  memory write data.
REQ-010 Port: mem_we  output  1  memory write enable, one cycle per stored byte.
REQ-011 Port: cpu_hold  output  1  holds the processor (PC, fetch) while high.
REQ-012 Port: done  output  1  image loaded and verified; high in RUN.
REQ-013 Port: error  output  1  checksum mismatch; high in ERR.

Function
REQ-014 FSM states: IDLE, LOAD, CHECK, RUN, ERR, encoded as a registered state.
REQ-015 Stream format: header byte N, then payload bytes, then (if enabled) one checksum byte; N=0 means 256 payload bytes.
REQ-016 IDLE: in_ready=1; accepted byte is latched as count N, address counter set to BASE_ADDR, running sum cleared; next state LOAD.
REQ-017 LOAD: in_ready=1; each accepted byte is written one cycle later: mem_we=1, mem_addr=address counter value at acceptance, mem_wdata=byte.
REQ-018 Address counter increments by 1 per accepted payload byte, 8-bit wrap from 8'hFF to 8'h00.
REQ-019 Running sum = 8-bit modulo sum of all payload bytes; carry discarded.
REQ-020 Back-to-back transfers at one byte per cycle are sustained with no bubble; gaps in in_valid stall without side effects.
REQ-021 After the N-th payload byte is accepted: next state CHECK (checksum enabled) or RUN (disabled).
REQ-022 CHECK: in_ready=1; accepted byte equal to running sum -> RUN, else -> ERR; the checksum byte is never written to memory.
REQ-023 RUN: in_ready=0, cpu_hold=0, done=1, mem_we=0.
REQ-024 ERR: in_ready=0, cpu_hold=1, error=1, mem_we=0.
REQ-025 reload in RUN or ERR -> IDLE next cycle; reload in IDLE/LOAD/CHECK is ignored.
REQ-026 cpu_hold=1 in every state except RUN; it deasserts the cycle after the last write's mem_we pulse at the earliest.
REQ-027 mem_we is never high in the same cycle as done.

Reset
REQ-028 reset forces state IDLE, counters and sum to 0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, in_ready=0 in the reset cycle.
REQ-029 reset asserted mid-LOAD discards the partial image; a pending write scheduled for the following cycle is cancelled.
REQ-030 reset has priority over reload and over stream transfers in the same cycle.

Configuration
REQ-031 Macro PROG_LOADER_CKSUM_EN: defined -> CHECK state, checksum byte and error path present; undefined -> no CHECK/ERR, error tied 0, LOAD goes directly to RUN.

Structure
REQ-032 Shared package holds the state enumeration constants and the stream-format constant (header count width 8, N=0 meaning 256).
REQ-033 No sub-module; single module with FSM, 9-bit remaining-count register, address counter, sum register, write-pipeline register.

Verification
REQ-034 Stream 03,10,20,30,60 (checksum on), BASE_ADDR=0 -> writes 00:10,01:20,02:30; RUN; done=1, cpu_hold=0.
REQ-035 Stream 02,AA,BB,00 -> checksum 8'h65 expected, mismatch -> ERR, error=1, cpu_hold=1; reload -> IDLE.
REQ-036 BASE_ADDR=8'hFE, stream 03,01,02,03,06 -> writes FE,FF,00; address wraps; RUN.
REQ-037 Header 00 then 256 bytes of 01, checksum 00 -> 256 writes covering 00..FF; RUN.
REQ-038 reset pulsed after 2nd of 4 payload bytes -> no further mem_we, state IDLE, cpu_hold=1; new load completes normally.
REQ-039 Checksum disabled build, stream 01,7F -> one write 00:7F, RUN two cycles after the header-plus-payload stream, error never asserted.
